uart_mmio: RTL
==============

UART_MMIO -- requirements
Module: uart_mmio

Interface
REQ-001 Parameter TX_DEPTH, default 16: TX FIFO entries; power of two, >=2.
REQ-002 Parameter RX_DEPTH, default 16: RX FIFO entries; power of two, >=2.
REQ-003 Parameter BASE_ADDR, default 32'h10010000: register block base, 16-byte aligned.
REQ-004 Parameter BAUD_RESET, default 16'h3: reset value of baud_max.
REQ-005 Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- address  in  32  CPU byte address.
- write_data  in  32  CPU write data.
- write_enable  in  1  CPU write strobe.
- read_enable  in  1  CPU read strobe.
- read_data  out  32  registered read data.
- read_valid  out  1  read_data valid.
- tx_data  out  8  byte to serializer.
- tx_start  out  1  one-cycle launch pulse.
- tx_busy  in  1  serializer shifting.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle received-byte pulse.
- baud_max  out  16  serializer divisor.
- irq  out  1  level interrupt.

Function
REQ-006 Hit = address in [BASE_ADDR, BASE_ADDR+0xF]; non-hit strobes have no effect and produce no read_valid.
REQ-007 Offset 0x0 DATA: write pushes write_data[7:0] to the TX FIFO; read returns {24'b0, RX head} and pops; read when RX empty returns 0 with no pop.
REQ-008 Offset 0x4 STATUS (read-only): bit0 rx_not_empty, bit1 rx_full, bit2 tx_empty, bit3 tx_full, bit4 tx_active (FSM not T_IDLE or tx_busy), bit5 rx_overrun, bit6 tx_overflow, other bits 0.
REQ-009 Offset 0x8 CTRL: bit0 rx_irq_en, bit1 tx_irq_en are read/write; writing 1 to bit8 clears both sticky error flags; bit8 reads 0.
REQ-010 Offset 0xC BAUD: bits[15:0] read/write, drive baud_max directly.
REQ-011 Read latency: read_valid high exactly one cycle after a hit read_enable, for one cycle, with read_data held until the next read; the pop occurs in the request cycle.
REQ-012 Simultaneous write_enable and read_enable: both performed.
REQ-013 TX push when full is dropped and sets tx_overflow, unless a TX pop occurs the same cycle, in which case it is accepted.
REQ-014 RX push on rx_valid; when full the byte is dropped and rx_overrun set, unless a CPU pop occurs the same cycle, in which case it is accepted.
REQ-015 FIFO occupancy counters are $clog2(DEPTH)+1 bits; pointers wrap modulo DEPTH; push and pop on one cycle leave count unchanged.
REQ-016 TX FSM states T_IDLE, T_LAUNCH, T_GUARD, T_WAIT.
REQ-017 T_IDLE -> T_LAUNCH when the TX FIFO is non-empty and tx_busy=0; the head is latched into tx_data and popped on that transition.
REQ-018 T_LAUNCH: tx_start=1 for exactly this cycle, then -> T_GUARD.
REQ-019 T_GUARD lasts one cycle, ignores tx_busy, then -> T_WAIT.
REQ-020 T_WAIT -> T_IDLE when tx_busy=0.
REQ-021 Back-to-back bytes are separated by at least 3 cycles between tx_start pulses.
REQ-022 irq = (rx_irq_en & rx_not_empty) | (tx_irq_en & tx_empty & FSM in T_IDLE) | rx_overrun | tx_overflow; irq is registered.
REQ-023 Sticky flags: a set and a clear in the same cycle results in set.

Reset
REQ-024 On rst low, asynchronously:
- all of the following are 0: read_data, read_valid, tx_data, tx_start, irq, CTRL, sticky flags.
- both FIFOs empty, FSM in T_IDLE, baud_max = BAUD_RESET.
REQ-025 Reset mid-transfer drops all FIFO contents and deasserts tx_start immediately; operation resumes on the first clock edge after rst is released.

Verification
REQ-026 Write 0x41, 0x42 to DATA with tx_busy modelled 10 cycles -> tx_start pulses carry 0x41 then 0x42, and STATUS afterwards reads 0x04.
REQ-027 Write 17 bytes with tx_busy held 1 (TX_DEPTH=16) -> 16 bytes retained, STATUS bit3=1 and bit6=1, irq=1; CTRL write 0x100 clears bit6.
REQ-028 Pulse rx_valid with 0x5A, read DATA -> read_valid the next cycle with read_data=0x5A; a second read returns 0 and STATUS bit0=0.
REQ-029 17 rx_valid pulses with no reads -> rx_overrun=1, the first 16 bytes are read back in order, and pointer wrap is exercised on refill.
REQ-030 Write 0x0010 to BAUD, read BAUD -> baud_max=16 and read_data=0x10; drop rst during T_WAIT -> baud_max=3, FIFOs empty, tx_start=0.

Source files
------------

// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped UART front end with TX/RX byte FIFOs,
// a TX launch FSM feeding an external serializer, and a level irq.
// Ports: clk, rst (async active-low); CPU bus address, write_data,
// write_enable, read_enable, read_data, read_valid; serializer side
// tx_data, tx_start, tx_busy, baud_max; receiver side rx_data,
// rx_valid; irq.
module uart_mmio #(
    parameter int          TX_DEPTH   = 16,
    parameter int          RX_DEPTH   = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h10010000,
    parameter logic [15:0] BAUD_RESET = 16'h3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic        write_enable,
    input  logic        read_enable,
    output logic [31:0] read_data,
    output logic        read_valid,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [15:0] baud_max,
    output logic        irq
);

    localparam int TAW = $clog2(TX_DEPTH);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam logic [TAW:0] TX_CAP = (TAW + 1)'(TX_DEPTH);
    localparam logic [RAW:0] RX_CAP = (RAW + 1)'(RX_DEPTH);

    typedef enum logic [1:0] {
        T_IDLE, T_LAUNCH, T_GUARD, T_WAIT
    } tx_state_t;

    tx_state_t state, state_n;

    // Bus decode
    logic       hit;
    logic [1:0] off;
    logic       wr_hit, rd_hit;
    logic       unused_bits;

    assign hit    = (address[31:4] == BASE_ADDR[31:4]);
    assign off    = address[3:2];
    assign wr_hit = hit & write_enable;
    assign rd_hit = hit & read_enable;
    assign unused_bits = ^{address[1:0], write_data[31:16]};

    // TX FIFO
    logic [7:0]   tx_mem [TX_DEPTH];
    logic [TAW-1:0] tx_wr, tx_rd;
    logic [TAW:0] tx_count;
    logic         tx_empty, tx_full;
    logic         tx_req, tx_push, tx_pop;

    assign tx_empty = (tx_count == '0);
    assign tx_full  = (tx_count == TX_CAP);
    assign tx_req   = wr_hit & (off == 2'd0);
    // A full FIFO still accepts when the FSM frees a slot this cycle.
    assign tx_push  = tx_req & (~tx_full | tx_pop);

    // RX FIFO
    logic [7:0]   rx_mem [RX_DEPTH];
    logic [RAW-1:0] rx_wr, rx_rd;
    logic [RAW:0] rx_count;
    logic         rx_empty, rx_full;
    logic         rx_push, rx_pop;

    assign rx_empty = (rx_count == '0);
    assign rx_full  = (rx_count == RX_CAP);
    assign rx_pop   = rd_hit & (off == 2'd0) & ~rx_empty;
    assign rx_push  = rx_valid & (~rx_full | rx_pop);

    // Control and sticky flags
    logic rx_irq_en, tx_irq_en;
    logic rx_overrun, tx_overflow;
    logic err_clr, ovr_set, ovf_set;

    assign err_clr = wr_hit & (off == 2'd2) & write_data[8];
    assign ovr_set = rx_valid & ~rx_push;
    assign ovf_set = tx_req & ~tx_push;

    logic tx_active;
    assign tx_active = (state != T_IDLE) | tx_busy;

    // FSM next state
    always_comb begin
        state_n = state;
        tx_pop  = 1'b0;
        unique case (state)
            T_IDLE: begin
                if (!tx_empty && !tx_busy) begin
                    state_n = T_LAUNCH;
                    tx_pop  = 1'b1;
                end
            end
            T_LAUNCH: state_n = T_GUARD;
            T_GUARD:  state_n = T_WAIT;
            T_WAIT: begin
                if (!tx_busy)
                    state_n = T_IDLE;
            end
            default: state_n = T_IDLE;
        endcase
    end

    // Decoded from state so reset removes the pulse immediately.
    assign tx_start = (state == T_LAUNCH);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= T_IDLE;
            tx_data <= 8'h0;
        end else begin
            state <= state_n;
            if (tx_pop)
                tx_data <= tx_mem[tx_rd];
        end
    end

    // FIFO storage carries no reset; occupancy defines validity.
    always_ff @(posedge clk) begin
        if (tx_push)
            tx_mem[tx_wr] <= write_data[7:0];
        if (rx_push)
            rx_mem[rx_wr] <= rx_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_wr    <= '0;
            tx_rd    <= '0;
            tx_count <= '0;
        end else begin
            if (tx_push)
                tx_wr <= tx_wr + 1'b1;
            if (tx_pop)
                tx_rd <= tx_rd + 1'b1;
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + 1'b1;
                2'b01:   tx_count <= tx_count - 1'b1;
                default: tx_count <= tx_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_wr    <= '0;
            rx_rd    <= '0;
            rx_count <= '0;
        end else begin
            if (rx_push)
                rx_wr <= rx_wr + 1'b1;
            if (rx_pop)
                rx_rd <= rx_rd + 1'b1;
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + 1'b1;
                2'b01:   rx_count <= rx_count - 1'b1;
                default: rx_count <= rx_count;
            endcase
        end
    end

    // Registers; a set wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_irq_en   <= 1'b0;
            tx_irq_en   <= 1'b0;
            rx_overrun  <= 1'b0;
            tx_overflow <= 1'b0;
            baud_max    <= BAUD_RESET;
        end else begin
            if (wr_hit && off == 2'd2) begin
                rx_irq_en <= write_data[0];
                tx_irq_en <= write_data[1];
            end
            if (wr_hit && off == 2'd3)
                baud_max <= write_data[15:0];
            if (ovr_set)
                rx_overrun <= 1'b1;
            else if (err_clr)
                rx_overrun <= 1'b0;
            if (ovf_set)
                tx_overflow <= 1'b1;
            else if (err_clr)
                tx_overflow <= 1'b0;
        end
    end

    // Read path
    logic [31:0] rd_val;

    always_comb begin
        rd_val = 32'h0;
        case (off)
            2'd0: rd_val = rx_empty ? 32'h0 : {24'h0, rx_mem[rx_rd]};
            2'd1: rd_val = {25'h0, tx_overflow, rx_overrun, tx_active,
                            tx_full, tx_empty, rx_full, ~rx_empty};
            2'd2: rd_val = {30'h0, tx_irq_en, rx_irq_en};
            2'd3: rd_val = {16'h0, baud_max};
            default: rd_val = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            read_data  <= 32'h0;
            read_valid <= 1'b0;
        end else begin
            read_valid <= rd_hit;
            if (rd_hit)
                read_data <= rd_val;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            irq <= 1'b0;
        else
            irq <= (rx_irq_en & ~rx_empty)
                 | (tx_irq_en & tx_empty & (state == T_IDLE))
                 | rx_overrun | tx_overflow;
    end

endmodule
